// File: rtl/tal_multilane_ctrl.sv
// Multi-lane parking barrier controller: one raise/up/lower FSM per entry lane,
// all lanes sharing a single occupancy-plus-reservation count for the lot.
module tal_multilane_ctrl #(
  parameter int N_LANES   = 2,
  parameter int N_EXITS   = 1,
  parameter int CAPACITY  = 4,
  parameter int RAISE_CYC = 3,
  parameter int LOWER_CYC = 3,
  parameter int TIMEOUT   = 16,
  localparam int CW = $clog2(CAPACITY + 1)
) (
  input  logic                   clk,
  input  logic                   R,
  input  logic [N_LANES-1:0]     T,
  input  logic [N_LANES-1:0]     V,
  input  logic [N_LANES-1:0]     C,
  input  logic [N_EXITS-1:0]     EXIT,
  output logic [2*N_LANES-1:0]   TAL,
  output logic                   FULL,
  output logic [CW-1:0]          FREE
);

  localparam int TMAX0 = (RAISE_CYC > LOWER_CYC) ? RAISE_CYC : LOWER_CYC;
  localparam int TMAX  = (TMAX0 > TIMEOUT) ? TMAX0 : TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int SW    = CW + 5;

  localparam logic [TW-1:0] RAISE_T   = TW'(RAISE_CYC);
  localparam logic [TW-1:0] LOWER_T   = TW'(LOWER_CYC);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] CAP_S     = SW'(CAPACITY);

  localparam logic [1:0] TAL_DOWN     = 2'd0;
  localparam logic [1:0] TAL_UPSTART  = 2'd1;
  localparam logic [1:0] TAL_UP       = 2'd2;
  localparam logic [1:0] TAL_DNSTART  = 2'd3;

  typedef enum logic [1:0] {IDLE, RAISE, UP, LOWER} laneStateT;

  laneStateT           laneState [N_LANES];
  logic [TW-1:0]       timer     [N_LANES];
  logic [N_LANES-1:0]  seen;
  logic [CW-1:0]       used;
  logic [CW-1:0]       usedNext;
  logic [N_LANES-1:0]  grant;
  logic [N_LANES-1:0]  timeoutHit;
  logic [SW-1:0]       nGrant;
  logic [SW-1:0]       nTimeout;
  logic [SW-1:0]       nExit;
  logic [SW-1:0]       addSum;
  logic [SW-1:0]       subSum;
  logic [SW-1:0]       diff;

  // Grants go lowest lane first against the count held at the start of the cycle.
  always_comb begin
    grant  = '0;
    nGrant = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (R && laneState[i] == IDLE && T[i] && V[i] &&
          (SW'(used) + nGrant) < CAP_S) begin
        grant[i] = 1'b1;
        nGrant   = nGrant + SW'(1);
      end
    end
  end

  always_comb begin
    timeoutHit = '0;
    nTimeout   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (laneState[i] == UP && !seen[i] && timer[i] == TIMEOUT_T) begin
        timeoutHit[i] = 1'b1;
        nTimeout      = nTimeout + SW'(1);
      end
    end
  end

  always_comb begin
    nExit = '0;
    for (int j = 0; j < N_EXITS; j++) begin
      if (EXIT[j]) nExit = nExit + SW'(1);
    end
  end

  // Net all count changes of this cycle and clamp into [0, CAPACITY].
  always_comb begin
    addSum   = SW'(used) + nGrant;
    subSum   = nTimeout + nExit;
    diff     = '0;
    usedNext = '0;
    if (subSum < addSum) begin
      diff = addSum - subSum;
      usedNext = (diff > CAP_S) ? CW'(CAPACITY) : CW'(diff);
    end
  end

  always_comb begin
    TAL = '0;
    for (int i = 0; i < N_LANES; i++) begin
      case (laneState[i])
        IDLE:    TAL[2*i +: 2] = grant[i] ? TAL_UPSTART : TAL_DOWN;
        RAISE:   TAL[2*i +: 2] = TAL_UPSTART;
        UP:      TAL[2*i +: 2] = TAL_UP;
        default: TAL[2*i +: 2] = (R && C[i]) ? TAL_UPSTART : TAL_DNSTART;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      for (int i = 0; i < N_LANES; i++) begin
        laneState[i] <= IDLE;
        timer[i]     <= '0;
      end
      seen <= '0;
      used <= '0;
      FULL <= 1'b0;
      FREE <= CW'(CAPACITY);
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        case (laneState[i])
          IDLE: begin
            if (grant[i]) begin
              laneState[i] <= RAISE;
              timer[i]     <= TW'(1);
            end
          end
          RAISE: begin
            if (timer[i] == RAISE_T) begin
              laneState[i] <= UP;
              timer[i]     <= '0;
            end else begin
              timer[i] <= timer[i] + TW'(1);
            end
          end
          UP: begin
            if (C[i]) seen[i] <= 1'b1;
            if (seen[i] && !C[i]) begin
              laneState[i] <= LOWER;
              timer[i]     <= TW'(1);
            end else if (timeoutHit[i]) begin
              laneState[i] <= LOWER;
              timer[i]     <= TW'(1);
            end else if (!seen[i]) begin
              timer[i] <= timer[i] + TW'(1);
            end
          end
          default: begin
            // A car under a closing barrier re-opens it without touching the count.
            if (C[i]) begin
              laneState[i] <= RAISE;
              timer[i]     <= TW'(1);
            end else if (timer[i] == LOWER_T) begin
              laneState[i] <= IDLE;
              timer[i]     <= '0;
              seen[i]      <= 1'b0;
            end else begin
              timer[i] <= timer[i] + TW'(1);
            end
          end
        endcase
      end
      used <= usedNext;
      FULL <= (usedNext == CW'(CAPACITY));
      FREE <= CW'(CAPACITY) - usedNext;
    end
  end

endmodule
